// File: rtl/encode_pkg.sv
// Shared helpers for the serial link: counter width sizing and even parity.
package encode_pkg;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Zero-extension leaves the parity unchanged, so narrower vectors may be passed in.
  function automatic logic even_par(input logic [63:0] vec);
    return ^vec;
  endfunction

endpackage

// File: rtl/deserial_counter.sv
// Wrapping bit counter 0..p_scale with a combinational wrap pulse on the last increment.
module deserial_counter
  import encode_pkg::*;
#(
  parameter int p_scale = 7
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pre,
  input  logic                          i_inc,
  output logic [cnt_w(p_scale+1)-1:0]   o_cnt,
  output logic                          o_inc
);

  localparam int cw = cnt_w(p_scale + 1);
  typedef logic [cw-1:0] cnt_t;

  cnt_t cnt;
  logic at_last;

  assign at_last = (cnt == cnt_t'(p_scale));

  // i_pre lets a restart consume the strobe of the same cycle as count 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= i_pre ? cnt_t'(1) : cnt_t'(0);
    end else if (i_inc) begin
      cnt <= at_last ? cnt_t'(0) : cnt + cnt_t'(1);
    end
  end

  assign o_cnt = cnt;
  assign o_inc = i_inc & ~i_rst & at_last;

endmodule

// File: rtl/deserial.sv
// Serial-to-parallel receiver, LSB first, with frame restart on i_syn.
// Optional even-parity bit per frame when DESERIAL_PARITY_EN is defined.
module deserial
  import encode_pkg::*;
#(
  parameter int p_width = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_val,
  input  logic               i_stp,
  input  logic               i_syn,
  output logic [p_width-1:0] o_val,
  output logic               o_stp,
  output logic               o_err
);

`ifdef DESERIAL_PARITY_EN
  localparam int frame_len = p_width + 1;
`else
  localparam int frame_len = p_width;
`endif
  localparam int cw = cnt_w(frame_len);

  logic [cw-1:0]      cnt;
  logic               done;
  logic               par_err;
  logic [p_width-1:0] shift_p0;
  logic [p_width-1:0] shift_nxt;

  deserial_counter #(
    .p_scale(frame_len - 1)
  ) u_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst | i_syn),
    .i_pre(i_syn & i_stp & ~i_rst),
    .i_inc(i_stp),
    .o_cnt(cnt),
    .o_inc(done)
  );

  // A strobe with i_syn is bit0 of a fresh word regardless of the counter.
  always_comb begin
    shift_nxt = shift_p0;
    if (i_syn) shift_nxt = '0;
    if (i_stp) begin
      for (int k = 0; k < p_width; k++) begin
        if (i_syn ? (k == 0) : (int'(cnt) == k)) shift_nxt[k] = i_val;
      end
    end
  end

`ifdef DESERIAL_PARITY_EN
  assign par_err = even_par(64'(shift_nxt)) ^ i_val;
`else
  assign par_err = 1'b0;
`endif

  // p0 -> output: word and strobe appear one clock after the last bit strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_p0 <= '0;
      o_val    <= '0;
      o_stp    <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      shift_p0 <= shift_nxt;
      o_stp    <= done;
      o_err    <= done & par_err;
      if (done) o_val <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_deserial.sv
// Directed + randomized bench for deserial, checked every cycle against a bit-queue model.
module tb_deserial;

  localparam int W = 8;
`ifdef DESERIAL_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk = 1'b0;
  logic         i_rst = 1'b1, i_val = 1'b0, i_stp = 1'b0, i_syn = 1'b0;
  logic [W-1:0] o_val;
  logic         o_stp, o_err;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int pulses[$];

  bit           mq[$];
  logic [W-1:0] exp_val = '0;
  logic         exp_stp = 1'b0;
  logic         exp_err = 1'b0;

  deserial #(.p_width(W)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_val(i_val), .i_stp(i_stp), .i_syn(i_syn),
    .o_val(o_val), .o_stp(o_stp), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: collect bits since the last boundary; a full frame yields a word.
  task automatic model(input logic rst, input logic syn, input logic stp, input logic val);
    logic [W-1:0] w;
    if (rst) begin
      mq.delete();
      exp_val = '0;
      exp_stp = 1'b0;
      exp_err = 1'b0;
    end else begin
      exp_stp = 1'b0;
      exp_err = 1'b0;
      if (syn) mq.delete();
      if (stp) mq.push_back(val);
      if (mq.size() == N) begin
        for (int i = 0; i < W; i++) w[i] = mq[i];
        exp_val = w;
        exp_stp = 1'b1;
`ifdef DESERIAL_PARITY_EN
        exp_err = (^w) ^ mq[W];
`endif
        mq.delete();
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic syn, input logic stp, input logic val);
    i_rst = rst; i_syn = syn; i_stp = stp; i_val = val;
    @(posedge clk);
    model(rst, syn, stp, val);
    #1;
    cyc_n++;
    if (o_stp === 1'b1) pulses.push_back(cyc_n);
    chk("stp", W'(o_stp), W'(exp_stp));
    chk("val", o_val, exp_val);
    chk("err", W'(o_err), W'(exp_err));
  endtask

  task automatic send_word(input logic [W-1:0] w, input int maxgap);
    for (int i = 0; i < N; i++) begin
      logic b;
      b = (i < W) ? w[i] : ^w;
      cyc(1'b0, 1'b0, 1'b1, b);
      if (maxgap > 0) begin
        int g;
        g = $urandom_range(maxgap, 0);
        for (int j = 0; j < g; j++) cyc(1'b0, 1'b0, 1'b0, 1'($urandom));
      end
    end
  endtask

  initial begin
    // reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_val", o_val, '0);
    chk("rst_stp", W'(o_stp), '0);

    // 1: back-to-back A5
    send_word(8'hA5, 0);
    chk("t1_stp", W'(o_stp), W'(1));
    chk("t1_val", o_val, 8'hA5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_stp_low", W'(o_stp), '0);

    // 2: random gaps
    pulses.delete();
    send_word(8'hA5, 5);
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_val", o_val, 8'hA5);
    chk("t2_npulse", W'(pulses.size()), W'(1));

    // 3: two words back-to-back, pulses N clocks apart
    pulses.delete();
    send_word(8'h3C, 0);
    chk("t3_val0", o_val, 8'h3C);
    send_word(8'hC3, 0);
    chk("t3_val1", o_val, 8'hC3);
    chk("t3_npulse", W'(pulses.size()), W'(2));
    if (pulses.size() == 2) chk("t3_spacing", W'(pulses[1] - pulses[0]), W'(N));

    // 4: junk bits, then re-align on a strobe
    pulses.delete();
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 1; j < W; j++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef DESERIAL_PARITY_EN
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
`endif
    chk("t4_val", o_val, 8'h01);
    chk("t4_npulse", W'(pulses.size()), W'(1));

    // 5: reset mid-word, then FF
    pulses.delete();
    for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_val_rst", o_val, '0);
    for (int j = 0; j < W - 1; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_val_pre", o_val, '0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
`ifdef DESERIAL_PARITY_EN
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
`endif
    chk("t5_val", o_val, 8'hFF);
    chk("t5_npulse", W'(pulses.size()), W'(1));

    // sync restart without a strobe, and sync on the completion strobe
    for (int j = 0; j < N - 1; j++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j < N - 1; j++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("syn_last_nostp", W'(o_stp), '0);

`ifdef DESERIAL_PARITY_EN
    // 6: parity good and bad
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b0, 1'b1, 8'hA5 >> i);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_err0", W'(o_err), '0);
    chk("t6_val0", o_val, 8'hA5);
    for (int i = 0; i < W; i++) cyc(1'b0, 1'b0, 1'b1, 8'hA5 >> i);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t6_err1", W'(o_err), W'(1));
    chk("t6_stp1", W'(o_stp), W'(1));
    chk("t6_val1", o_val, 8'hA5);
`endif

    // randomized traffic
    for (int j = 0; j < 800; j++) begin
      cyc(($urandom % 150) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
